uart_rx_frame_ctrl: RTL and testbench
=====================================

Name: uart_rx_frame_ctrl

Overview:
- Frame sequencer for the Hamming-code serial receive path.
- Watches the serial line, times the start, data and stop bits, and issues a mid-bit sample strobe for the receive datapath.
- Validates each 17-bit frame: 1 start bit (0), 15 codeword bits MSB-first, 1 stop bit (1).
- Buffers good codewords in a small FIFO with valid/ready handshake toward the Hamming decoder. Reports framing and overrun errors.

Parameters:
- CLKS_PER_BIT, 4, clocks per serial bit; minimum 1. HALF = CLKS_PER_BIT/2 (integer division).
- FIFO_DEPTH, 2, codeword buffer entries; power of 2, minimum 2.

Ports:
- clk_ctrl  in  1  single clock; all logic on its rising edge.
- rst_ctrl  in  1  asynchronous reset, active-high.
- msg_in_ctrl  in  1  serial line; idles high.
- bit_tick_ctrl  out  1  one-cycle strobe on every accepted sample (start confirm, data, stop).
- busy_ctrl  out  1  high while the FSM is not in IDLE.
- word_out_ctrl  out  15  head of FIFO; bit 14 is the first received data bit.
- word_valid_ctrl  out  1  FIFO not empty.
- word_ready_ctrl  in  1  consumer accepts the head word when both valid and ready are high.
- frame_err_ctrl  out  1  sticky: a stop bit was sampled as 0.
- overrun_ctrl  out  1  sticky: a good word arrived while the FIFO was full.
- clr_err_ctrl  in  1  synchronous clear of both sticky flags.
- fifo_level_ctrl  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async assert, release synchronous to clk_ctrl):
  - FSM goes to IDLE; bit counter and timer are 0.
  - FIFO is empty; word_out_ctrl = 15'h7FFF.
  - All 1-bit outputs are 0; fifo_level_ctrl = 0.
  - Reset asserted mid-frame discards the partial frame. FIFO contents are lost.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: first cycle with the line low is T0; go to START with timer = 0.
  - START: at T0+HALF, re-sample the line.
    - Low: pulse bit_tick_ctrl and go to DATA.
    - High: false start; return to IDLE. No flag is set.
    - With CLKS_PER_BIT = 1 the T0 sample itself is the confirmation.
  - DATA: bit k (k = 0..14) is sampled at T0+HALF+(k+1)*CLKS_PER_BIT and shifted in MSB-first. After k = 14, go to STOP.
  - STOP: sample at T0+HALF+16*CLKS_PER_BIT.
    - 1: push the word, then go to IDLE.
    - 0: set frame_err_ctrl, discard the word, then go to WAIT_HIGH.
  - WAIT_HIGH: stay until the line is sampled high, then go to IDLE. This prevents a stuck-low line from producing endless frames.
- A new frame may be detected in the cycle immediately after the STOP→IDLE transition. Back-to-back frames are supported.
- FIFO:
  - A pushed word becomes visible on word_out_ctrl with word_valid_ctrl = 1 on the cycle after the stop sample edge.
  - Push while full (with no simultaneous pop) drops the new word, sets overrun_ctrl, and leaves FIFO contents unchanged.
  - Simultaneous push and pop when full: both occur, no overrun, level unchanged.
  - Simultaneous push and pop when empty: the push is accepted, and the pop is a no-op because valid was 0.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - word_out_ctrl holds 15'h7FFF whenever the FIFO is empty.
- Sticky flags:
  - clr_err_ctrl clears both flags on the next edge.
  - If a set event and clr_err_ctrl occur in the same cycle, set wins.

Optional Feature:
- Macro: RX_SYNC_EN.
- Defined: msg_in_ctrl passes through a 2-flop synchronizer, reset to 1, before all FSM logic. This adds exactly 2 cycles from the line edge to T0; all other timing is relative to T0 and unchanged.
- Undefined: msg_in_ctrl is used directly. The source must already be synchronous to clk_ctrl.

Test Plan:
- Good frame, CLKS_PER_BIT=4: reset, then send start, 15'h2AAA MSB-first, stop=1 → bit_tick_ctrl pulses 17 times; word_valid_ctrl=1 with word_out_ctrl=15'h2AAA at T0+67; frame_err_ctrl=0.
- False start: 1-cycle low glitch, then line high → FSM returns to IDLE; no word pushed; no flags set; busy_ctrl low again by T0+3.
- Framing error: frame with data 15'h7FFF and stop=0 → frame_err_ctrl=1; FIFO level stays 0; FSM holds in WAIT_HIGH until the line goes high. clr_err_ctrl then clears the flag.
- Overrun: word_ready_ctrl=0, send 3 good frames 15'h0001, 15'h0002, 15'h0003 → level=2; overrun_ctrl=1. Raise ready → reads 15'h0001 then 15'h0002; 15'h0003 is lost.
- Full push+pop: FIFO full, ready=1 during the third frame's push cycle → no overrun; level stays 2; order is preserved.
- Reset mid-frame: assert rst_ctrl at data bit 7 → all outputs return to reset values immediately. The next complete frame 15'h1234 is received correctly.

Source files
------------

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: frame sequencer for the Hamming-code serial receive path.
// Detects a start bit, samples 15 codeword bits MSB-first at mid-bit, checks
// the stop bit and buffers good codewords in a small valid/ready FIFO.
// Sticky frame_err_ctrl / overrun_ctrl flags report bad stop bits and dropped words.
// Optional macro RX_SYNC_EN: when defined, msg_in_ctrl passes through a
// 2-flop synchronizer (reset to 1) before any FSM logic.
module uart_rx_frame_ctrl #(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 2
) (
    input  logic                          clk_ctrl,
    input  logic                          rst_ctrl,
    input  logic                          msg_in_ctrl,
    output logic                          bit_tick_ctrl,
    output logic                          busy_ctrl,
    output logic [14:0]                   word_out_ctrl,
    output logic                          word_valid_ctrl,
    input  logic                          word_ready_ctrl,
    output logic                          frame_err_ctrl,
    output logic                          overrun_ctrl,
    input  logic                          clr_err_ctrl,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_ctrl
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int TMR_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [TMR_W-1:0] BIT_LAST  = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [TMR_W-1:0] HALF_LAST = TMR_W'((HALF > 0) ? HALF - 1 : 0);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    logic line;

`ifdef RX_SYNC_EN
    logic [1:0] sync_q;
    logic [1:0] sync_d;

    // Shift the raw line through two flops; idle level is high
    always_comb begin
        sync_d = {sync_q[0], msg_in_ctrl};
    end

    // Synchronizer flops reset to the idle (high) line level
    always_ff @(posedge clk_ctrl or posedge rst_ctrl) begin
        if (rst_ctrl) sync_q <= 2'b11;
        else          sync_q <= sync_d;
    end

    assign line = sync_q[1];
`else
    assign line = msg_in_ctrl;
`endif

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic               tick_q, tick_d;
    logic               busy_q, busy_d;
    logic [14:0]        shift_q, shift_d;
    logic               push;
    logic               frame_set;

    // Frame timing: start confirm at T0+HALF, then one sample every CLKS_PER_BIT
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tick_d    = 1'b0;
        push      = 1'b0;
        frame_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!line) begin
                    timer_d   = '0;
                    bit_cnt_d = '0;
                    // With a 1-clock bit the detecting sample is the confirmation
                    if (HALF == 0) begin
                        tick_d  = 1'b1;
                        state_d = S_DATA;
                    end else begin
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                if (timer_q == HALF_LAST) begin
                    timer_d = '0;
                    if (!line) begin
                        tick_d  = 1'b1;
                        state_d = S_DATA;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_DATA: begin
                if (timer_q == BIT_LAST) begin
                    timer_d = '0;
                    tick_d  = 1'b1;
                    shift_d = {shift_q[13:0], line};
                    if (bit_cnt_q == 4'd14) begin
                        bit_cnt_d = '0;
                        state_d   = S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_STOP: begin
                if (timer_q == BIT_LAST) begin
                    timer_d = '0;
                    tick_d  = 1'b1;
                    if (line) begin
                        push    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        frame_set = 1'b1;
                        state_d   = S_WAIT_HIGH;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_WAIT_HIGH: begin
                // A stuck-low line must not be mistaken for a stream of start bits
                if (line) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // FSM state, counters and registered strobes
    always_ff @(posedge clk_ctrl or posedge rst_ctrl) begin
        if (rst_ctrl) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            bit_cnt_q <= '0;
            tick_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_cnt_q <= bit_cnt_d;
            tick_q    <= tick_d;
            busy_q    <= busy_d;
        end
    end

    // Received-bit shift register (data only, no reset needed)
    always_ff @(posedge clk_ctrl) begin
        shift_q <= shift_d;
    end

    logic [14:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic             pop, full, wr_en, ovr_set;

    // FIFO bookkeeping: a pop on a full FIFO frees the slot for a same-cycle push
    always_comb begin
        pop      = word_valid_ctrl && word_ready_ctrl;
        full     = (level_q == LVL_FULL);
        wr_en    = push && (!full || pop);
        ovr_set  = push && full && !pop;
        wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop   ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q;
        if (wr_en && !pop)      level_d = level_q + 1'b1;
        else if (!wr_en && pop) level_d = level_q - 1'b1;
        // Set has priority over clear so an event in the clear cycle is not lost
        frame_err_d = frame_set | (frame_err_q & ~clr_err_ctrl);
        overrun_d   = ovr_set   | (overrun_q   & ~clr_err_ctrl);
    end

    // FIFO pointers, occupancy and sticky error flags
    always_ff @(posedge clk_ctrl or posedge rst_ctrl) begin
        if (rst_ctrl) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    // Codeword storage (data only, no reset needed)
    always_ff @(posedge clk_ctrl) begin
        if (wr_en) mem_q[wr_ptr_q] <= shift_q;
    end

    assign bit_tick_ctrl   = tick_q;
    assign busy_ctrl       = busy_q;
    assign word_valid_ctrl = (level_q != '0);
    assign word_out_ctrl   = word_valid_ctrl ? mem_q[rd_ptr_q] : 15'h7FFF;
    assign frame_err_ctrl  = frame_err_q;
    assign overrun_ctrl    = overrun_q;
    assign fifo_level_ctrl = level_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Testbench for uart_rx_frame_ctrl (CLKS_PER_BIT=4, FIFO_DEPTH=2, default build).
module tb_uart_rx_frame_ctrl;

    localparam int C = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        line;
    logic        ready;
    logic        clr;
    logic        bit_tick;
    logic        busy;
    logic [14:0] word_out;
    logic        word_valid;
    logic        frame_err;
    logic        overrun;
    logic [1:0]  level;

    uart_rx_frame_ctrl #(.CLKS_PER_BIT(C), .FIFO_DEPTH(2)) dut (
        .clk_ctrl        (clk),
        .rst_ctrl        (rst),
        .msg_in_ctrl     (line),
        .bit_tick_ctrl   (bit_tick),
        .busy_ctrl       (busy),
        .word_out_ctrl   (word_out),
        .word_valid_ctrl (word_valid),
        .word_ready_ctrl (ready),
        .frame_err_ctrl  (frame_err),
        .overrun_ctrl    (overrun),
        .clr_err_ctrl    (clr),
        .fifo_level_ctrl (level)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          tick_cnt = 0;
    int          rise_cyc = -1;
    int          t0 = 0;
    logic        prev_valid = 1'b0;
    logic [14:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Scoreboard: every handshake pops the oldest expected word
    always @(negedge clk) begin
        if (!rst) begin
            if (bit_tick) tick_cnt++;
            if (word_valid && !prev_valid) rise_cyc = cyc;
            if (word_valid && ready) begin
                if (exp_q.size() == 0) begin
                    check("pop_unexpected", 32'(exp_q.size()), 32'd1);
                end else begin
                    logic [14:0] e;
                    e = exp_q.pop_front();
                    check("pop_word", 32'(word_out), 32'(e));
                end
            end
        end
        prev_valid = word_valid;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one frame, one cycle per loop pass; t0 is the cycle the line goes low.
    // pop_at >= 0 raises ready only in that cycle; abort_at >= 0 stops early.
    task automatic send_frame(input logic [14:0] w, input logic stop_b,
                              input int pop_at, input int abort_at);
        logic [16:0] bits;
        bits = {1'b0, w, stop_b};
        t0 = cyc;
        for (int i = 0; i < 17 * C; i++) begin
            if (i == abort_at) return;
            line = bits[16 - i / C];
            if (pop_at >= 0) ready = (i == pop_at);
            step(1);
        end
    endtask

    int t0l;

    initial begin
        rst = 1'b1; line = 1'b1; ready = 1'b0; clr = 1'b0;
        step(3);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tick", 32'(bit_tick), 32'd0);
        check("rst_valid", 32'(word_valid), 32'd0);
        check("rst_word", 32'(word_out), 32'h7FFF);
        check("rst_ferr", 32'(frame_err), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        rst = 1'b0;
        step(2);

        // Good frame 15'h2AAA
        tick_cnt = 0;
        rise_cyc = -1;
        exp_q.push_back(15'h2AAA);
        send_frame(15'h2AAA, 1'b1, -1, -1);
        line = 1'b1;
        step(3);
        check("good_ticks", 32'(tick_cnt), 32'd17);
        check("good_latency", 32'(rise_cyc - t0), 32'd67);
        check("good_valid", 32'(word_valid), 32'd1);
        check("good_word", 32'(word_out), 32'h2AAA);
        check("good_ferr", 32'(frame_err), 32'd0);
        check("good_level", 32'(level), 32'd1);
        ready = 1'b1;
        step(1);
        ready = 1'b0;
        check("drain1_level", 32'(level), 32'd0);

        // False start: one-cycle glitch
        t0l = cyc;
        line = 1'b0;
        step(1);
        line = 1'b1;
        check("fs_busy_hi", 32'(busy), 32'd1);
        step(2);
        check("fs_cycle", 32'(cyc - t0l), 32'd3);
        check("fs_busy_lo", 32'(busy), 32'd0);
        step(4);
        check("fs_valid", 32'(word_valid), 32'd0);
        check("fs_ferr", 32'(frame_err), 32'd0);
        check("fs_ovr", 32'(overrun), 32'd0);

        // Framing error with stuck-low line
        send_frame(15'h7FFF, 1'b0, -1, -1);
        step(8);
        check("fe_flag", 32'(frame_err), 32'd1);
        check("fe_level", 32'(level), 32'd0);
        check("fe_wait_busy", 32'(busy), 32'd1);
        line = 1'b1;
        step(2);
        check("fe_idle", 32'(busy), 32'd0);
        check("fe_sticky", 32'(frame_err), 32'd1);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        check("fe_clear", 32'(frame_err), 32'd0);

        // Overrun: three frames into a 2-deep FIFO with ready low
        exp_q.push_back(15'h0001);
        exp_q.push_back(15'h0002);
        send_frame(15'h0001, 1'b1, -1, -1);
        send_frame(15'h0002, 1'b1, -1, -1);
        send_frame(15'h0003, 1'b1, -1, -1);
        line = 1'b1;
        step(2);
        check("ovr_level", 32'(level), 32'd2);
        check("ovr_flag", 32'(overrun), 32'd1);
        check("ovr_head", 32'(word_out), 32'h0001);
        ready = 1'b1;
        step(2);
        ready = 1'b0;
        check("ovr_drained", 32'(level), 32'd0);
        check("ovr_empty_word", 32'(word_out), 32'h7FFF);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        check("ovr_clear", 32'(overrun), 32'd0);

        // Full FIFO with pop coinciding with the third push
        exp_q.push_back(15'h0004);
        exp_q.push_back(15'h0005);
        exp_q.push_back(15'h0006);
        send_frame(15'h0004, 1'b1, -1, -1);
        send_frame(15'h0005, 1'b1, -1, -1);
        send_frame(15'h0006, 1'b1, 66, -1);
        line = 1'b1;
        step(1);
        check("pp_ovr", 32'(overrun), 32'd0);
        check("pp_level", 32'(level), 32'd2);
        check("pp_head", 32'(word_out), 32'h0005);
        ready = 1'b1;
        step(2);
        ready = 1'b0;
        check("pp_drained", 32'(level), 32'd0);

        // Reset in the middle of data bit 7 with a word already buffered
        send_frame(15'h0F0F, 1'b1, -1, -1);
        send_frame(15'h5555, 1'b1, -1, (1 + 7) * C + 2);
        check("mr_busy_before", 32'(busy), 32'd1);
        check("mr_level_before", 32'(level), 32'd1);
        rst = 1'b1;
        #2;
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_valid", 32'(word_valid), 32'd0);
        check("mr_level", 32'(level), 32'd0);
        check("mr_word", 32'(word_out), 32'h7FFF);
        check("mr_tick", 32'(bit_tick), 32'd0);
        check("mr_flags", 32'({frame_err, overrun}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        line = 1'b1;
        step(2);
        exp_q.push_back(15'h1234);
        send_frame(15'h1234, 1'b1, -1, -1);
        line = 1'b1;
        step(2);
        check("mr_next_valid", 32'(word_valid), 32'd1);
        check("mr_next_word", 32'(word_out), 32'h1234);
        ready = 1'b1;
        step(1);
        ready = 1'b0;
        check("mr_next_drained", 32'(level), 32'd0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
